// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: data-memory controller for the MEM stage.
//
// Accepts one load/store at a time and drives a 32-bit asynchronous SRAM
// with per-byte enables. Stores are placed in the correct byte lane; loads
// are sign- or zero-extended. Read and write wait states are parameterised.
// Misaligned or reserved-size requests are answered with resp_err and never
// reach the SRAM.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req_*              pipeline request; req_ready high only in IDLE
//   resp_valid/_rdata/_err  one-cycle completion pulse with load data / error
//   busy               stall to the pipeline, high whenever not IDLE
//   sram_*             SRAM address, data out + tristate enable, data in,
//                      active-low byte enables and ce/oe/we strobes
module mem_sram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, RESP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             sgn_q;

  // Address bits above the SRAM window alias and are deliberately dropped.
  generate
    if (ADDR_W < 30) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    end
  endgenerate

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be_n(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_be_n = ~(4'b0001 << off);
      2'b01:   store_be_n = off[1] ? 4'b0011 : 4'b1100;
      default: store_be_n = 4'b0000;
    endcase
  endfunction

  // Narrow stores are replicated across lanes; be_n picks the live lane.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_ext = {{24{sgn & b[7]}}, b};
      2'b01:   load_ext = {{16{sgn & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_be_n  <= 4'hF;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            sgn_q  <= req_signed;
            if (misaligned(req_size, req_addr[1:0])) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we) begin
              state_q    <= WR_SETUP;
              sram_addr  <= req_addr[ADDR_W+1:2];
              sram_dq_o  <= store_data(req_size, req_wdata);
              sram_be_n  <= store_be_n(req_size, req_addr[1:0]);
              sram_dq_oe <= 1'b1;
              sram_ce_n  <= 1'b0;
            end else begin
              state_q    <= RD_ACC;
              cnt_q      <= RD_LOAD;
              sram_addr  <= req_addr[ADDR_W+1:2];
              sram_be_n  <= 4'h0;
              sram_ce_n  <= 1'b0;
              sram_oe_n  <= 1'b0;
            end
          end
        end
        RD_ACC: begin
          if (cnt_q == '0) begin
            state_q    <= RESP;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_ext(sram_dq_i, size_q, off_q, sgn_q);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WR_SETUP: begin
          state_q   <= WR_PULSE;
          cnt_q     <= WR_LOAD;
          sram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt_q == '0) begin
            state_q   <= WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WR_HOLD: begin
          // Data stays driven one cycle past the we_n rising edge.
          state_q    <= RESP;
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_be_n  <= 4'hF;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          state_q    <= IDLE;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
module tb_mem_sram_ctrl;

  localparam int ADDR_W  = 20;
  localparam int RD_WAIT = 3;
  localparam int WR_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [31:0]       sram_dq_i;
  logic [3:0]        sram_be_n;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  mem_sram_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model
  logic [31:0] mem [0:255];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int i = 0; i < 4; i++)
        if (!sram_be_n[i]) mem[sram_addr[7:0]][8*i +: 8] <= sram_dq_o[8*i +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log [0:63];
  int   acc_cnt  = 0;
  int   cyc      = 0;
  int   we_lo    = 0;
  int   ce_lo    = 0;
  int   busy_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepts, pops the scoreboard on every response.
  always @(negedge clk) begin
    if (rst) begin
      if (!sram_we_n) we_lo++;
      if (!sram_ce_n) ce_lo++;
      if (acc_q.size() > 0 && cyc >= acc_q[0] && !busy) busy_gap++;
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc + 1);
        if (acc_cnt < 64) acc_log[acc_cnt] = cyc + 1;
        acc_cnt++;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check_eq("unexpected_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check_eq({e.tag, "_rdata"}, resp_rdata, e.rdata);
          check_eq({e.tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          check_eq({e.tag, "_latency"}, cyc - a, e.lat);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rd);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check_eq({tag, "_ready_timeout"}, {31'b0, req_ready}, 32'h1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    e.tag = tag; e.err = exp_err; e.rdata = exp_rd;
    e.lat = exp_err ? 0 : (we ? WR_WAIT + 2 : RD_WAIT);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("idle_timeout", exp_q.size(), 32'h0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    logic [31:0] snap;
    int          base;
    int          n;
    int          nresp;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset state
    #3 rst = 1'b0;
    #20;
    check_eq("rst_ce_n", {31'b0, sram_ce_n}, 32'h1);
    check_eq("rst_oe_n", {31'b0, sram_oe_n}, 32'h1);
    check_eq("rst_we_n", {31'b0, sram_we_n}, 32'h1);
    check_eq("rst_be_n", {28'b0, sram_be_n}, 32'hF);
    check_eq("rst_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_addr", 32'(sram_addr), 32'h0);
    check_eq("rst_ready", {31'b0, req_ready}, 32'h1);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Byte store: lane 1
    we_lo = 0;
    issue("sb5", 1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0000_00A5, 1'b0, 32'h0);
    check_eq("sb5_addr", 32'(sram_addr), 32'h1);
    check_eq("sb5_be_n", {28'b0, sram_be_n}, 32'hD);
    check_eq("sb5_dq_o", sram_dq_o, 32'hA5A5_A5A5);
    check_eq("sb5_dq_oe", {31'b0, sram_dq_oe}, 32'h1);
    check_eq("sb5_setup_we_n", {31'b0, sram_we_n}, 32'h1);
    wait_idle();
    check_eq("sb5_we_width", we_lo, WR_WAIT);

    // Byte loads
    issue("lb5", 1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0, 1'b0, 32'hFFFF_FFA5);
    check_eq("lb5_oe_n", {31'b0, sram_oe_n}, 32'h0);
    check_eq("lb5_be_n", {28'b0, sram_be_n}, 32'h0);
    check_eq("lb5_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
    wait_idle();
    issue("lbu5", 1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0, 1'b0, 32'h0000_00A5);
    wait_idle();

    // Word store, half/word loads
    issue("sw10", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    check_eq("sw10_be_n", {28'b0, sram_be_n}, 32'h0);
    check_eq("sw10_dq_o", sram_dq_o, 32'hDEAD_BEEF);
    wait_idle();
    issue("lh12", 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 1'b0, 32'hFFFF_DEAD);
    wait_idle();
    issue("lhu10", 1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_BEEF);
    wait_idle();
    issue("lw10", 1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
    wait_idle();

    // Upper-half store, then read back the merged word (aliased address)
    issue("sh6", 1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_1234, 1'b0, 32'h0);
    check_eq("sh6_be_n", {28'b0, sram_be_n}, 32'h3);
    check_eq("sh6_dq_o", sram_dq_o, 32'h1234_1234);
    wait_idle();
    issue("lw4_alias", 1'b0, 2'b10, 1'b0, 32'hF040_0004, 32'h0, 1'b0, 32'h1234_A500);
    wait_idle();

    // Misaligned / reserved size
    ce_lo = 0;
    issue("lw6_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 1'b1, 32'h0);
    wait_idle();
    check_eq("lw6_ce_untouched", ce_lo, 0);
    snap = mem[0];
    ce_lo = 0;
    issue("sh3_mis", 1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_FFFF, 1'b1, 32'h0);
    wait_idle();
    check_eq("sh3_ce_untouched", ce_lo, 0);
    check_eq("sh3_mem_unchanged", mem[0], snap);
    issue("size11", 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0);
    wait_idle();

    // Held req_valid: store then load presented continuously
    base = acc_cnt;
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0010; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    exp_q.push_back('{tag: "sw_held", err: 1'b0, rdata: 32'h0, lat: WR_WAIT + 2});
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'h0;
    exp_q.push_back('{tag: "lw_held", err: 1'b0, rdata: 32'hCAFE_F00D, lat: RD_WAIT});
    n = 0;
    while (acc_cnt < base + 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    check_eq("held_interval", acc_log[base+1] - acc_log[base], WR_WAIT + 4);
    wait_idle();
    check_eq("busy_gaps", busy_gap, 0);

    // Abort a write mid-pulse with reset
    issue("sw_abort", 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0);
    n = 0;
    while (sram_we_n && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("abort_saw_we_low", {31'b0, sram_we_n}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_we_n_async", {31'b0, sram_we_n}, 32'h1);
    check_eq("abort_ce_n_async", {31'b0, sram_ce_n}, 32'h1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    check_eq("abort_ready", {31'b0, req_ready}, 32'h1);
    check_eq("abort_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) nresp++;
    end
    check_eq("abort_no_resp", nresp, 0);
    issue("lw_after_abort", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hCAFE_F00D);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
